// File: rtl/power_domain_sequencer_pkg.sv
// Shared types and constants for the three-domain power sequencer.
// Bit/instance index 0 = ALU, 1 = MEM, 2 = IO throughout.
package pg_seq_pkg;

  localparam int NUM_PD = 3;
  localparam int PD_ALU = 0;
  localparam int PD_MEM = 1;
  localparam int PD_IO  = 2;

  typedef enum logic [2:0] {
    ON      = 3'd0,
    SAVE    = 3'd1,
    ISOLATE = 3'd2,
    OFF     = 3'd3,
    PWR_UP  = 3'd4,
    RESTORE = 3'd5,
    RELEASE = 3'd6
  } pd_state_t;

  function automatic int pd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pd_seq_channel.sv
// One power domain: Moore FSM plus a shared down-counter for the isolation
// hold and the power-switch ramp. Power-up waits for an external grant.
module pd_seq_channel
  import pg_seq_pkg::*;
#(
  parameter int ISO_DELAY    = 2,
  parameter int SWITCH_DELAY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic gate_req,
  input  logic wake_req,
  input  logic pu_grant,
  output logic pu_req,
  output logic in_pwr_up,
  output logic ret_save,
  output logic ret_restore,
  output logic iso_en,
  output logic pwr_sw_en,
  output logic domain_ready,
  output logic wake_ack,
  output logic busy
);

  localparam int CNT_W = $clog2(pd_max(ISO_DELAY, SWITCH_DELAY)) + 1;

  pd_state_t        r_state;
  pd_state_t        w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_wakeAck;
  logic             w_cntDone;

  assign w_cntDone = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ON;
      r_cnt     <= '0;
      r_wakeAck <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_wakeAck <= (r_state == RELEASE);
    end
  end

  // Wake has priority everywhere power is still on; a started power-up
  // always runs to completion regardless of gate_req.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      ON: begin
        if (gate_req && !wake_req) w_stateNext = SAVE;
      end
      SAVE: begin
        if (wake_req) begin
          w_stateNext = RELEASE;
        end else begin
          w_stateNext = ISOLATE;
          w_cntNext   = CNT_W'(ISO_DELAY);
        end
      end
      ISOLATE: begin
        if (wake_req) begin
          w_stateNext = RELEASE;
          w_cntNext   = '0;
        end else if (w_cntDone) begin
          w_stateNext = OFF;
          w_cntNext   = '0;
        end else if (r_cnt > CNT_W'(1)) begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      OFF: begin
        if (pu_grant) begin
          w_stateNext = PWR_UP;
          w_cntNext   = CNT_W'(SWITCH_DELAY);
        end
      end
      PWR_UP: begin
        if (w_cntDone) begin
          w_stateNext = RESTORE;
          w_cntNext   = '0;
        end else if (r_cnt > CNT_W'(1)) begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      RESTORE: w_stateNext = RELEASE;
      RELEASE: w_stateNext = ON;
      default: begin
        w_stateNext = ON;
        w_cntNext   = '0;
      end
    endcase
  end

  assign pu_req       = (r_state == OFF) && (wake_req || !gate_req);
  assign in_pwr_up    = (r_state == PWR_UP);
  assign ret_save     = (r_state == SAVE);
  assign ret_restore  = (r_state == RESTORE);
  assign iso_en       = (r_state inside {ISOLATE, OFF, PWR_UP, RESTORE, RELEASE});
  assign pwr_sw_en    = (r_state != OFF);
  assign domain_ready = (r_state == ON);
  assign wake_ack     = r_wakeAck;
  assign busy         = (r_state != ON) && (r_state != OFF);

endmodule

// File: rtl/power_domain_sequencer.sv
// Top level: three domain channels sharing one inrush limiter that lets
// only one power switch ramp at a time, fixed priority ALU > MEM > IO.
module power_domain_sequencer
  import pg_seq_pkg::*;
#(
  parameter int ISO_DELAY    = 2,
  parameter int SWITCH_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PD-1:0] gate_req,
  input  logic [NUM_PD-1:0] wake_req,
  output logic [NUM_PD-1:0] ret_save,
  output logic [NUM_PD-1:0] ret_restore,
  output logic [NUM_PD-1:0] iso_en,
  output logic [NUM_PD-1:0] pwr_sw_en,
  output logic [NUM_PD-1:0] domain_ready,
  output logic [NUM_PD-1:0] wake_ack,
  output logic              busy
);

  logic [NUM_PD-1:0] w_puReq;
  logic [NUM_PD-1:0] w_puGrant;
  logic [NUM_PD-1:0] w_inPwrUp;
  logic [NUM_PD-1:0] w_busy;

  // No new grant while any switch is still ramping.
  always_comb begin
    w_puGrant = '0;
    if (!(|w_inPwrUp)) begin
      if (w_puReq[PD_ALU])      w_puGrant[PD_ALU] = 1'b1;
      else if (w_puReq[PD_MEM]) w_puGrant[PD_MEM] = 1'b1;
      else if (w_puReq[PD_IO])  w_puGrant[PD_IO]  = 1'b1;
    end
  end

  assign busy = |w_busy;

  for (genvar g = 0; g < NUM_PD; g++) begin : g_pd
    pd_seq_channel #(
      .ISO_DELAY   (ISO_DELAY),
      .SWITCH_DELAY(SWITCH_DELAY)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .gate_req    (gate_req[g]),
      .wake_req    (wake_req[g]),
      .pu_grant    (w_puGrant[g]),
      .pu_req      (w_puReq[g]),
      .in_pwr_up   (w_inPwrUp[g]),
      .ret_save    (ret_save[g]),
      .ret_restore (ret_restore[g]),
      .iso_en      (iso_en[g]),
      .pwr_sw_en   (pwr_sw_en[g]),
      .domain_ready(domain_ready[g]),
      .wake_ack    (wake_ack[g]),
      .busy        (w_busy[g])
    );
  end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Scoreboarded bench: each scenario queues the output events it expects,
// a negedge monitor logs what the sequencer actually does, and they are matched.
module tb_power_domain_sequencer;
  import pg_seq_pkg::*;

  localparam int ISO = 2;
  localparam int SW  = 4;

  localparam int EV_SAVE    = 0;
  localparam int EV_RESTORE = 1;
  localparam int EV_ACK     = 2;
  localparam int EV_RISE    = 3;
  localparam int EV_FALL    = 4;

  typedef struct {
    int cyc;
    int kind;
    int dom;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] gate_req;
  logic [2:0] wake_req;
  logic [2:0] ret_save;
  logic [2:0] ret_restore;
  logic [2:0] iso_en;
  logic [2:0] pwr_sw_en;
  logic [2:0] domain_ready;
  logic [2:0] wake_ack;
  logic       busy;

  int         cycCount   = 0;
  int         checkCount = 0;
  int         passCount  = 0;
  int         invViol    = 0;
  logic [2:0] prevPwr    = 3'b111;
  ev_t        expQ[$];
  ev_t        obsQ[$];

  power_domain_sequencer #(
    .ISO_DELAY   (ISO),
    .SWITCH_DELAY(SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gate_req    (gate_req),
    .wake_req    (wake_req),
    .ret_save    (ret_save),
    .ret_restore (ret_restore),
    .iso_en      (iso_en),
    .pwr_sw_en   (pwr_sw_en),
    .domain_ready(domain_ready),
    .wake_ack    (wake_ack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  // Event log stamped with the index of the most recent rising edge; also
  // tracks the rule that isolation is on whenever the switch is off or toggles.
  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        if (ret_save[d])    obsQ.push_back('{cycCount, EV_SAVE, d});
        if (ret_restore[d]) obsQ.push_back('{cycCount, EV_RESTORE, d});
        if (wake_ack[d])    obsQ.push_back('{cycCount, EV_ACK, d});
        if (pwr_sw_en[d] && !prevPwr[d]) obsQ.push_back('{cycCount, EV_RISE, d});
        if (!pwr_sw_en[d] && prevPwr[d]) obsQ.push_back('{cycCount, EV_FALL, d});
        if (!pwr_sw_en[d] && !iso_en[d]) invViol++;
        if ((pwr_sw_en[d] != prevPwr[d]) && !iso_en[d]) invViol++;
      end
    end
    prevPwr = pwr_sw_en;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit takeObs(input ev_t e);
    foreach (obsQ[i]) begin
      if (obsQ[i].cyc == e.cyc && obsQ[i].kind == e.kind && obsQ[i].dom == e.dom) begin
        obsQ.delete(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic waitUntil(input int target);
    int guard = 0;
    while (cycCount < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    gate_req = 3'b000;
    wake_req = 3'b000;
    repeat (3) @(negedge clk);
    checkCount++;
    if (pwr_sw_en !== 3'b111) $display("[TB] FAIL reset_pwr: got %b, required 111", pwr_sw_en);
    else passCount++;
    checkCount++;
    if (iso_en !== 3'b000) $display("[TB] FAIL reset_iso: got %b, required 000", iso_en);
    else passCount++;
    checkCount++;
    if (domain_ready !== 3'b111) $display("[TB] FAIL reset_ready: got %b, required 111", domain_ready);
    else passCount++;
    checkCount++;
    if ({ret_save, ret_restore, wake_ack} !== 9'b0)
      $display("[TB] FAIL reset_pulses: got %b, required 0", {ret_save, ret_restore, wake_ack});
    else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, required 0", busy);
    else passCount++;
    reset = 1'b0;
    @(negedge clk);
    obsQ.delete();
    invViol = 0;
  endtask

  task automatic test_gate_alu();
    int e;
    @(negedge clk);
    gate_req = 3'b001;
    e = cycCount + 1;
    expQ.push_back('{e, EV_SAVE, 0});
    expQ.push_back('{e + 1 + ISO, EV_FALL, 0});
    waitUntil(e);
    checkCount++;
    if (ret_save !== 3'b001 || iso_en !== 3'b000)
      $display("[TB] FAIL gate_save_cycle: got save=%b iso=%b, required save=001 iso=000", ret_save, iso_en);
    else passCount++;
    waitUntil(e + 1);
    checkCount++;
    if (iso_en !== 3'b001 || pwr_sw_en !== 3'b111 || busy !== 1'b1)
      $display("[TB] FAIL gate_isolate: got iso=%b pwr=%b busy=%b, required 001/111/1", iso_en, pwr_sw_en, busy);
    else passCount++;
    waitUntil(e + 1 + ISO);
    checkCount++;
    if (pwr_sw_en !== 3'b110 || iso_en !== 3'b001 || domain_ready !== 3'b110 || busy !== 1'b0)
      $display("[TB] FAIL gate_off: got pwr=%b iso=%b ready=%b busy=%b, required 110/001/110/0",
               pwr_sw_en, iso_en, domain_ready, busy);
    else passCount++;
    waitUntil(e + ISO + 4);
    while (expQ.size() > 0) begin
      ev_t x = expQ.pop_front();
      checkCount++;
      if (takeObs(x)) passCount++;
      else $display("[TB] FAIL gate_event: kind %0d dom %0d got absent, required at cycle %0d", x.kind, x.dom, x.cyc);
    end
    checkCount++;
    if (obsQ.size() !== 0) begin
      $display("[TB] FAIL gate_extra: got %0d unexpected events (first kind %0d dom %0d cyc %0d), required 0",
               obsQ.size(), obsQ[0].kind, obsQ[0].dom, obsQ[0].cyc);
      obsQ.delete();
    end else passCount++;
  endtask

  task automatic test_wake_alu();
    int e;
    @(negedge clk);
    wake_req = 3'b001;
    gate_req = 3'b000;
    e = cycCount + 1;
    expQ.push_back('{e, EV_RISE, 0});
    expQ.push_back('{e + SW, EV_RESTORE, 0});
    expQ.push_back('{e + SW + 2, EV_ACK, 0});
    @(negedge clk);
    wake_req = 3'b000;
    checkCount++;
    if (pwr_sw_en !== 3'b111 || iso_en !== 3'b001 || busy !== 1'b1)
      $display("[TB] FAIL wake_pwrup: got pwr=%b iso=%b busy=%b, required 111/001/1", pwr_sw_en, iso_en, busy);
    else passCount++;
    waitUntil(e + SW + 1);
    checkCount++;
    if (domain_ready !== 3'b110)
      $display("[TB] FAIL wake_release: got ready=%b, required 110", domain_ready);
    else passCount++;
    waitUntil(e + SW + 2);
    checkCount++;
    if (domain_ready !== 3'b111 || iso_en !== 3'b000 || busy !== 1'b0)
      $display("[TB] FAIL wake_on: got ready=%b iso=%b busy=%b, required 111/000/0", domain_ready, iso_en, busy);
    else passCount++;
    waitUntil(e + SW + 5);
    while (expQ.size() > 0) begin
      ev_t x = expQ.pop_front();
      checkCount++;
      if (takeObs(x)) passCount++;
      else $display("[TB] FAIL wake_event: kind %0d dom %0d got absent, required at cycle %0d", x.kind, x.dom, x.cyc);
    end
    checkCount++;
    if (obsQ.size() !== 0) begin
      $display("[TB] FAIL wake_extra: got %0d unexpected events (first kind %0d dom %0d cyc %0d), required 0",
               obsQ.size(), obsQ[0].kind, obsQ[0].dom, obsQ[0].cyc);
      obsQ.delete();
    end else passCount++;
  endtask

  task automatic test_inrush_all();
    int e;
    @(negedge clk);
    gate_req = 3'b111;
    e = cycCount + 1;
    for (int d = 0; d < 3; d++) begin
      expQ.push_back('{e, EV_SAVE, d});
      expQ.push_back('{e + 1 + ISO, EV_FALL, d});
    end
    waitUntil(e + ISO + 3);
    checkCount++;
    if (pwr_sw_en !== 3'b000 || iso_en !== 3'b111)
      $display("[TB] FAIL all_off: got pwr=%b iso=%b, required 000/111", pwr_sw_en, iso_en);
    else passCount++;
    @(negedge clk);
    wake_req = 3'b111;
    gate_req = 3'b000;
    e = cycCount + 1;
    for (int k = 0; k < 3; k++) begin
      int g = e + k * (SW + 1);
      expQ.push_back('{g, EV_RISE, k});
      expQ.push_back('{g + SW, EV_RESTORE, k});
      expQ.push_back('{g + SW + 2, EV_ACK, k});
    end
    @(negedge clk);
    wake_req = 3'b000;
    waitUntil(e + SW);
    checkCount++;
    if (pwr_sw_en !== 3'b001)
      $display("[TB] FAIL inrush_alu_only: got pwr=%b, required 001", pwr_sw_en);
    else passCount++;
    waitUntil(e + SW + 1);
    checkCount++;
    if (pwr_sw_en !== 3'b011)
      $display("[TB] FAIL inrush_mem_next: got pwr=%b, required 011", pwr_sw_en);
    else passCount++;
    waitUntil(e + 2 * (SW + 1) + SW + 4);
    checkCount++;
    if (domain_ready !== 3'b111 || busy !== 1'b0)
      $display("[TB] FAIL inrush_done: got ready=%b busy=%b, required 111/0", domain_ready, busy);
    else passCount++;
    while (expQ.size() > 0) begin
      ev_t x = expQ.pop_front();
      checkCount++;
      if (takeObs(x)) passCount++;
      else $display("[TB] FAIL inrush_event: kind %0d dom %0d got absent, required at cycle %0d", x.kind, x.dom, x.cyc);
    end
    checkCount++;
    if (obsQ.size() !== 0) begin
      $display("[TB] FAIL inrush_extra: got %0d unexpected events (first kind %0d dom %0d cyc %0d), required 0",
               obsQ.size(), obsQ[0].kind, obsQ[0].dom, obsQ[0].cyc);
      obsQ.delete();
    end else passCount++;
  endtask

  task automatic test_abort_mem();
    int e;
    @(negedge clk);
    gate_req = 3'b010;
    e = cycCount + 1;
    expQ.push_back('{e, EV_SAVE, 1});
    expQ.push_back('{e + ISO + 2, EV_ACK, 1});
    waitUntil(e + ISO);
    checkCount++;
    if (iso_en !== 3'b010 || pwr_sw_en !== 3'b111)
      $display("[TB] FAIL abort_isolate: got iso=%b pwr=%b, required 010/111", iso_en, pwr_sw_en);
    else passCount++;
    wake_req = 3'b010;
    gate_req = 3'b000;
    @(negedge clk);
    wake_req = 3'b000;
    checkCount++;
    if (pwr_sw_en !== 3'b111 || iso_en !== 3'b010 || domain_ready !== 3'b101)
      $display("[TB] FAIL abort_release: got pwr=%b iso=%b ready=%b, required 111/010/101",
               pwr_sw_en, iso_en, domain_ready);
    else passCount++;
    waitUntil(e + ISO + 2);
    checkCount++;
    if (domain_ready !== 3'b111 || iso_en !== 3'b000)
      $display("[TB] FAIL abort_on: got ready=%b iso=%b, required 111/000", domain_ready, iso_en);
    else passCount++;
    waitUntil(e + ISO + 6);
    while (expQ.size() > 0) begin
      ev_t x = expQ.pop_front();
      checkCount++;
      if (takeObs(x)) passCount++;
      else $display("[TB] FAIL abort_event: kind %0d dom %0d got absent, required at cycle %0d", x.kind, x.dom, x.cyc);
    end
    checkCount++;
    if (obsQ.size() !== 0) begin
      $display("[TB] FAIL abort_extra: got %0d unexpected events (first kind %0d dom %0d cyc %0d), required 0",
               obsQ.size(), obsQ[0].kind, obsQ[0].dom, obsQ[0].cyc);
      obsQ.delete();
    end else passCount++;
  endtask

  task automatic test_gate_wake_held();
    int bad = 0;
    @(negedge clk);
    gate_req = 3'b100;
    wake_req = 3'b100;
    repeat (10) begin
      @(negedge clk);
      if (domain_ready !== 3'b111 || ret_save !== 3'b000 || busy !== 1'b0) bad++;
    end
    gate_req = 3'b000;
    wake_req = 3'b000;
    checkCount++;
    if (bad !== 0) $display("[TB] FAIL held_stay_on: got %0d off-nominal cycles, required 0", bad);
    else passCount++;
    checkCount++;
    if (obsQ.size() !== 0) begin
      $display("[TB] FAIL held_extra: got %0d unexpected events (first kind %0d dom %0d), required 0",
               obsQ.size(), obsQ[0].kind, obsQ[0].dom);
      obsQ.delete();
    end else passCount++;
  endtask

  task automatic test_reset_mid_pwrup();
    int e;
    @(negedge clk);
    gate_req = 3'b100;
    e = cycCount + 1;
    expQ.push_back('{e, EV_SAVE, 2});
    expQ.push_back('{e + 1 + ISO, EV_FALL, 2});
    waitUntil(e + ISO + 2);
    wake_req = 3'b100;
    gate_req = 3'b000;
    e = cycCount + 1;
    expQ.push_back('{e, EV_RISE, 2});
    @(negedge clk);
    wake_req = 3'b000;
    waitUntil(e + 2);
    checkCount++;
    if (busy !== 1'b1 || iso_en !== 3'b100)
      $display("[TB] FAIL midpu_before: got busy=%b iso=%b, required 1/100", busy, iso_en);
    else passCount++;
    #2 reset = 1'b1;
    #1;
    checkCount++;
    if (pwr_sw_en !== 3'b111 || iso_en !== 3'b000 || domain_ready !== 3'b111 || busy !== 1'b0)
      $display("[TB] FAIL midpu_async: got pwr=%b iso=%b ready=%b busy=%b, required 111/000/111/0",
               pwr_sw_en, iso_en, domain_ready, busy);
    else passCount++;
    checkCount++;
    if ({ret_save, ret_restore, wake_ack} !== 9'b0)
      $display("[TB] FAIL midpu_pulses: got %b, required 0", {ret_save, ret_restore, wake_ack});
    else passCount++;
    @(negedge clk);
    reset = 1'b0;
    repeat (SW + 3) @(negedge clk);
    checkCount++;
    if (domain_ready !== 3'b111 || busy !== 1'b0)
      $display("[TB] FAIL midpu_after: got ready=%b busy=%b, required 111/0", domain_ready, busy);
    else passCount++;
    while (expQ.size() > 0) begin
      ev_t x = expQ.pop_front();
      checkCount++;
      if (takeObs(x)) passCount++;
      else $display("[TB] FAIL midpu_event: kind %0d dom %0d got absent, required at cycle %0d", x.kind, x.dom, x.cyc);
    end
    checkCount++;
    if (obsQ.size() !== 0) begin
      $display("[TB] FAIL midpu_extra: got %0d unexpected events (first kind %0d dom %0d cyc %0d), required 0",
               obsQ.size(), obsQ[0].kind, obsQ[0].dom, obsQ[0].cyc);
      obsQ.delete();
    end else passCount++;
  endtask

  initial begin
    $display("[TB] power_domain_sequencer bench start");
    test_reset();
    test_gate_alu();
    test_wake_alu();
    test_inrush_all();
    test_abort_mem();
    test_gate_wake_held();
    test_reset_mid_pwrup();
    checkCount++;
    if (invViol !== 0) $display("[TB] FAIL iso_invariant: got %0d violations, required 0", invViol);
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
